// File: rtl/mips_mem_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, RAM depth.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int DEPTH_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response bus between the EX/MEM stage (master) and the load/store unit (slave).
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Big-endian lane extraction (with sign/zero extension) and lane merge for sub-word stores.
module lsu_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [15:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Lane 0 is the most significant byte, so the shift is 8*(3-lane).
    assign byte_sh  = {~lane, 3'b000};
    assign half_sh  = {~lane[1], 4'b0000};
    assign byte_val = word[byte_sh +: 8];
    assign half_val = word[half_sh +: 16];

    always_comb begin
        rdata  = word;
        merged = word;
        case (size)
            SIZE_BYTE: begin
                rdata = {{24{byte_val[7] & ~is_unsigned}}, byte_val};
                merged[byte_sh +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                rdata = {{16{half_val[15] & ~is_unsigned}}, half_val};
                merged[half_sh +: 16] = wdata;
            end
            default: begin
                rdata  = word;
                merged = word;
            end
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: converts byte/half/word requests into word RAM accesses, with
// read-modify-write for sub-word stores and rejection of misaligned/out-of-range requests.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    load_store_unit_if.slave  bus,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              MemRead,
    output logic              MemWrite
);
    lsu_state_t  state;
    logic        ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic        cap_write;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic [1:0]  cap_lane;
    logic [15:0] cap_wdata;

    logic        accept;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

    assign accept  = bus.req_valid & ready_q;
    assign req_err = ((bus.req_size == SIZE_HALF) && bus.req_addr[0])
                   || ((bus.req_size == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00))
                   || (bus.req_size == 2'b11)
                   || ((bus.req_addr >> 2) >= ADDR_W'(DEPTH));

    lsu_align u_align (
        .word        (mem_rdata),
        .lane        (cap_lane),
        .size        (cap_size),
        .is_unsigned (cap_unsigned),
        .wdata       (cap_wdata),
        .rdata       (load_data),
        .merged      (merged_word)
    );

    // Request fields are only consulted after acceptance, so they need no reset.
    always_ff @(posedge Clk) begin
        if (accept) begin
            cap_write    <= bus.req_write;
            cap_size     <= bus.req_size;
            cap_unsigned <= bus.req_unsigned;
            cap_lane     <= bus.req_addr[1:0];
            cap_wdata    <= bus.req_wdata[15:0];
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_address  <= '0;
            mem_wdata    <= '0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (req_err) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            state        <= RESP;
                        end else if (!bus.req_write || (bus.req_size != SIZE_WORD)) begin
                            mem_address <= bus.req_addr >> 2;
                            MemRead     <= 1'b1;
                            state       <= READ;
                        end else begin
                            mem_address <= bus.req_addr >> 2;
                            mem_wdata   <= bus.req_wdata;
                            MemWrite    <= 1'b1;
                            state       <= WRITE;
                        end
                    end
                end
                READ: begin
                    MemRead <= 1'b0;
                    if (cap_write) begin
                        mem_wdata <= merged_word;
                        MemWrite  <= 1'b1;
                        state     <= WRITE;
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_data;
                        state        <= RESP;
                    end
                end
                WRITE: begin
                    MemWrite     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    state        <= RESP;
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural 64-word RAM.
module tb_load_store_unit;
    import mips_mem_pkg::*;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
        int          lat;
        int          rdc;
        int          wrc;
    } vec_t;

    typedef struct {
        vec_t  v;
        int    acc;
        string nm;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        MemRead;
    logic        MemWrite;

    logic [31:0] ram [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   viol = 0;
    int   n_push = 0;
    int   n_pop = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    exp_t sb_q[$];

    load_store_unit_if #(.ADDR_W(32)) ifc ();

    load_store_unit #(.DEPTH(64), .ADDR_W(32)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .bus         (ifc),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(posedge Clk) begin
        if (MemWrite) ram[mem_address[5:0]] <= mem_wdata;
        else if (pl_en) ram[pl_idx] <= pl_val;
    end

    assign mem_rdata = ram[mem_address[5:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: counts RAM strobes per transaction and pops the scoreboard on each response.
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (MemRead) rd_cnt++;
            if (MemWrite) wr_cnt++;
            if (MemRead && MemWrite) viol++;
            if (ifc.req_ready && (MemRead || MemWrite || ifc.resp_valid)) viol++;
            if (ifc.resp_valid) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got response with empty queue, expected none");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    n_pop++;
                    chk({e.nm, "_err"}, {31'd0, ifc.resp_err}, {31'd0, e.v.err});
                    chk({e.nm, "_rdata"}, ifc.resp_rdata, e.v.rd);
                    chk({e.nm, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.v.lat));
                    chk({e.nm, "_nread"}, 32'(rd_cnt), 32'(e.v.rdc));
                    chk({e.nm, "_nwrite"}, 32'(wr_cnt), 32'(e.v.wrc));
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic un,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic err, input logic [31:0] rd,
                                input int lat, input int rdc, input int wrc);
        vec_t v;
        v.wr = wr; v.sz = sz; v.un = un; v.addr = addr; v.wd = wd;
        v.err = err; v.rd = rd; v.lat = lat; v.rdc = rdc; v.wrc = wrc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        ifc.req_write    = v.wr;
        ifc.req_size     = v.sz;
        ifc.req_unsigned = v.un;
        ifc.req_addr     = v.addr;
        ifc.req_wdata    = v.wd;
        ifc.req_valid    = 1'b1;
    endtask

    task automatic push(input vec_t v, input string nm);
        exp_t e;
        e.v = v; e.acc = cyc; e.nm = nm;
        sb_q.push_back(e);
        n_push++;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        @(negedge Clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(posedge Clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        @(negedge Clk);
        while ((sb_q.size() != 0 || !ifc.req_ready) && g < 30) begin
            @(negedge Clk);
            g++;
        end
        if (g >= 30) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
        end
    endtask

    task automatic issue(input vec_t v, input string nm);
        int g = 0;
        @(negedge Clk);
        while (!ifc.req_ready && g < 20) begin
            @(negedge Clk);
            g++;
        end
        if (!ifc.req_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_ready_timeout: got req_ready=0, expected 1", nm);
        end else begin
            drive(v);
            @(posedge Clk);
            #1;
            push(v, nm);
            ifc.req_valid = 1'b0;
            drain();
        end
    endtask

    vec_t hs[6];

    initial begin
        int idx;
        logic rdy;
        Rst_n = 1'b0;
        ifc.req_valid = 1'b0; ifc.req_write = 1'b0; ifc.req_size = 2'b00;
        ifc.req_unsigned = 1'b0; ifc.req_addr = '0; ifc.req_wdata = '0;
        repeat (2) @(negedge Clk);

        // Reset state
        chk("rst_ready", {31'd0, ifc.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, ifc.resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, ifc.resp_err}, 32'd0);
        chk("rst_resp_rdata", ifc.resp_rdata, 32'd0);
        chk("rst_memread", {31'd0, MemRead}, 32'd0);
        chk("rst_memwrite", {31'd0, MemWrite}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        Rst_n = 1'b1;

        // Reset asserted while a word store sits in WRITE
        preload(6'd2, 32'hCAFEF00D);
        @(negedge Clk);
        drive(mk(1'b1, SIZE_WORD, 1'b0, 32'h8, 32'h12345678, 1'b0, 32'h0, 2, 0, 1));
        @(posedge Clk);
        #1 ifc.req_valid = 1'b0;
        chk("midop_memwrite_before", {31'd0, MemWrite}, 32'd1);
        #1 Rst_n = 1'b0;
        #1;
        chk("midop_memwrite_after", {31'd0, MemWrite}, 32'd0);
        chk("midop_ready", {31'd0, ifc.req_ready}, 32'd1);
        chk("midop_mem_address", mem_address, 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        chk("midop_ram2", ram[2], 32'hCAFEF00D);

        // Word store then load
        issue(mk(1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, 0, 1), "sw10");
        chk("ram4_sw", ram[4], 32'hDEADBEEF);
        issue(mk(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1, 0), "lw10");

        // Byte and halfword loads
        preload(6'd4, 32'h80FF7F01);
        issue(mk(1'b0, SIZE_BYTE, 1'b0, 32'h10, 32'h0, 1'b0, 32'hFFFFFF80, 2, 1, 0), "lb10");
        issue(mk(1'b0, SIZE_BYTE, 1'b1, 32'h10, 32'h0, 1'b0, 32'h00000080, 2, 1, 0), "lbu10");
        issue(mk(1'b0, SIZE_BYTE, 1'b0, 32'h12, 32'h0, 1'b0, 32'h0000007F, 2, 1, 0), "lb12");
        issue(mk(1'b0, SIZE_BYTE, 1'b0, 32'h13, 32'h0, 1'b0, 32'h00000001, 2, 1, 0), "lb13");
        issue(mk(1'b0, SIZE_BYTE, 1'b0, 32'h11, 32'h0, 1'b0, 32'hFFFFFFFF, 2, 1, 0), "lb11");
        issue(mk(1'b0, SIZE_HALF, 1'b0, 32'h10, 32'h0, 1'b0, 32'hFFFF80FF, 2, 1, 0), "lh10");
        issue(mk(1'b0, SIZE_HALF, 1'b1, 32'h10, 32'h0, 1'b0, 32'h000080FF, 2, 1, 0), "lhu10");
        issue(mk(1'b0, SIZE_HALF, 1'b0, 32'h12, 32'h0, 1'b0, 32'h00007F01, 2, 1, 0), "lh12");

        // Sub-word stores (upper wdata bits must be ignored)
        preload(6'd4, 32'h11223344);
        issue(mk(1'b1, SIZE_BYTE, 1'b0, 32'h11, 32'h123456AA, 1'b0, 32'h0, 3, 1, 1), "sb11");
        chk("ram4_sb", ram[4], 32'h11AA3344);
        issue(mk(1'b1, SIZE_HALF, 1'b0, 32'h12, 32'hFFFFBEEF, 1'b0, 32'h0, 3, 1, 1), "sh12");
        chk("ram4_sh", ram[4], 32'h11AABEEF);
        issue(mk(1'b1, SIZE_BYTE, 1'b0, 32'h10, 32'h00000077, 1'b0, 32'h0, 3, 1, 1), "sb10");
        chk("ram4_sb0", ram[4], 32'h77AABEEF);

        // Errors and range boundary
        issue(mk(1'b0, SIZE_HALF, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0, 1, 0, 0), "lh11_err");
        preload(6'd0, 32'h00000000);
        issue(mk(1'b1, SIZE_WORD, 1'b0, 32'h100, 32'h55555555, 1'b1, 32'h0, 1, 0, 0), "sw100_err");
        chk("ram0_untouched", ram[0], 32'h00000000);
        issue(mk(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0, 0), "sz11_err");
        issue(mk(1'b1, SIZE_WORD, 1'b0, 32'h12, 32'h99999999, 1'b1, 32'h0, 1, 0, 0), "sw12_err");
        chk("ram4_after_err", ram[4], 32'h77AABEEF);
        preload(6'd63, 32'h0F0F0F0F);
        issue(mk(1'b0, SIZE_WORD, 1'b0, 32'hFC, 32'h0, 1'b0, 32'h0F0F0F0F, 2, 1, 0), "lwFC");

        // Handshake: req_valid held high for 10 cycles
        hs[0] = mk(1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h01020304, 1'b0, 32'h0, 2, 0, 1);
        hs[1] = mk(1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0, 1'b0, 32'h01020304, 2, 1, 0);
        hs[2] = mk(1'b1, SIZE_BYTE, 1'b0, 32'h21, 32'h0000005A, 1'b0, 32'h0, 3, 1, 1);
        hs[3] = mk(1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0, 1'b0, 32'h015A0304, 2, 1, 0);
        hs[4] = mk(1'b1, SIZE_WORD, 1'b0, 32'h24, 32'hA5A55A5A, 1'b0, 32'h0, 2, 0, 1);
        hs[5] = mk(1'b0, SIZE_HALF, 1'b0, 32'h22, 32'h0, 1'b0, 32'h00000304, 2, 1, 0);
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            if (idx < 6) drive(hs[idx]);
            rdy = ifc.req_ready;
            @(posedge Clk);
            #1;
            if (rdy && idx < 6) begin
                push(hs[idx], $sformatf("hs%0d", idx));
                idx++;
            end
        end
        @(negedge Clk);
        ifc.req_valid = 1'b0;
        drain();
        chk("hs_accepted", 32'(idx), 32'd3);
        chk("ram8_hs", ram[8], 32'h015A0304);

        chk("resp_count", 32'(n_pop), 32'(n_push));
        chk("queue_empty", 32'(sb_q.size()), 32'd0);
        chk("protocol_violations", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
